lighthouse_emitter: RTL and testbench

// Transmit side of the lighthouse optical protocol: synthesises the active-low sensor waveform
// (sync0, sync1, sweep pulse) that the lighthouse_sensor receive chain decodes. It drives a sensor
// pin from programmed angles and OOTX bits for closed-loop bring-up and regression of the

---
 rtl/lighthouse_emitter_pkg.sv | 47 ++++
 rtl/lighthouse_emitter_sync_encode.sv | 29 ++
 rtl/lighthouse_emitter.sv | 217 +++++++++++++++++++++
 tb/tb_lighthouse_emitter.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lighthouse_emitter_pkg.sv
// ----------------------------------------------------------------------------
// lighthouse_emitter_pkg
// Shared definitions for the lighthouse sync-pulse protocol on the transmit
// side. It holds the default sync pulse timing, the sweep-pulse length limit,
// the {skip,data,axis} sync code layout and the emitter FSM state encoding.
// No ports: this is a package.
// ----------------------------------------------------------------------------
package lighthouse_emitter_pkg;

    // Default sync pulse timing in system clocks (48 MHz).
    localparam int unsigned SYNC_BASE_CLK = 3072;
    localparam int unsigned SYNC_STEP_CLK = 512;

    // The sweep pulse has to stay below 15 us to be classed as a sweep.
    localparam int unsigned CLK_HZ        = 48_000_000;
    localparam int unsigned SWEEP_MAX_US  = 15;
    localparam int unsigned SWEEP_MAX_CLK = (CLK_HZ / 1_000_000) * SWEEP_MAX_US;

    // Sync code layout: code = {skip, data, axis}.
    localparam int unsigned CODE_W    = 3;
    localparam int unsigned CODE_AXIS = 0;
    localparam int unsigned CODE_DATA = 1;
    localparam int unsigned CODE_SKIP = 2;
    localparam int unsigned CODE_MAX  = (1 << CODE_W) - 1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SYNC0_LO,
        ST_SYNC0_HI,
        ST_SYNC1_LO,
        ST_SWEEP_WAIT,
        ST_SWEEP_LO,
        ST_TAIL
    } emit_state_e;

    function automatic logic [CODE_W-1:0] sync_code(input logic skip,
                                                    input logic data,
                                                    input logic axis);
        logic [CODE_W-1:0] c;
        c            = '0;
        c[CODE_SKIP] = skip;
        c[CODE_DATA] = data;
        c[CODE_AXIS] = axis;
        return c;
    endfunction

endpackage

// File: rtl/lighthouse_emitter_sync_encode.sv
// ----------------------------------------------------------------------------
// lighthouse_sync_encode
// Combinational sync-pulse encoder: maps the {skip,data,axis} code to the
// low length of the sync pulse. It is the exact inverse of the receiver's
// sync decoder: the extra half step puts the pulse in the middle of the
// decoder's bin.
// Ports:
//   skip_i, data_i, axis_i : code fields
//   len_o [WIDTH]          : sync low length in clocks
// ----------------------------------------------------------------------------
module lighthouse_sync_encode
    import lighthouse_emitter_pkg::*;
#(
    parameter int unsigned WIDTH     = 20,
    parameter int unsigned SYNC_BASE = SYNC_BASE_CLK,
    parameter int unsigned SYNC_STEP = SYNC_STEP_CLK
) (
    input  logic             skip_i,
    input  logic             data_i,
    input  logic             axis_i,
    output logic [WIDTH-1:0] len_o
);

    logic [CODE_W-1:0] code;

    assign code  = sync_code(skip_i, data_i, axis_i);
    assign len_o = WIDTH'(SYNC_BASE + SYNC_STEP / 2) + WIDTH'(code) * WIDTH'(SYNC_STEP);

endmodule

// File: rtl/lighthouse_emitter.sv
// ----------------------------------------------------------------------------
// lighthouse_emitter
// Synthesises the active-low lighthouse sensor waveform (sync0, sync1, sweep
// pulse) from programmed angles and OOTX bits, one frame of FRAME_LEN clocks
// at a time, cycling through frames 0..3.
// Ports:
//   clk_i                  : system clock
//   rst_ni                 : asynchronous reset, active low
//   enable_i               : emit frames; only looked at on frame boundaries
//   angle0_i..angle3_i     : sweep time per frame, sync1 rise to sweep mid
//   ootx_i [2]             : data bits for sync0/sync1 of the next frame
//   ootx_ack_o             : 1-cycle pulse when ootx/angle are latched
//   frame_idx_o [2]        : index of the frame being emitted
//   angle_err_o            : 1-cycle pulse, latched angle out of range
//   busy_o                 : a frame is in progress
//   pin_o                  : sensor waveform, idles high
// ----------------------------------------------------------------------------
module lighthouse_emitter
    import lighthouse_emitter_pkg::*;
#(
    parameter int unsigned WIDTH      = 20,
    parameter int unsigned FRAME_LEN  = 400000,
    parameter int unsigned SYNC_SPACE = 20000,
    parameter int unsigned SYNC_BASE  = SYNC_BASE_CLK,
    parameter int unsigned SYNC_STEP  = SYNC_STEP_CLK,
    parameter int unsigned SWEEP_LEN  = 240
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             enable_i,
    input  logic [WIDTH-1:0] angle0_i,
    input  logic [WIDTH-1:0] angle1_i,
    input  logic [WIDTH-1:0] angle2_i,
    input  logic [WIDTH-1:0] angle3_i,
    input  logic [1:0]       ootx_i,
    output logic             ootx_ack_o,
    output logic [1:0]       frame_idx_o,
    output logic             angle_err_o,
    output logic             busy_o,
    output logic             pin_o
);

    localparam int unsigned HALF     = SWEEP_LEN / 2;
    localparam int unsigned MAX_SYNC = SYNC_BASE + CODE_MAX * SYNC_STEP + SYNC_STEP / 2;
    localparam int unsigned EW       = WIDTH + 2;

    // Elaboration-time parameter sanity.
    if (FRAME_LEN >= (64'd1 << WIDTH)) begin : g_err_frame
        $error("lighthouse_emitter: FRAME_LEN does not fit in WIDTH bits");
    end
    if ((SWEEP_LEN % 2) != 0 || SWEEP_LEN == 0 || SWEEP_LEN >= SWEEP_MAX_CLK) begin : g_err_sweep
        $error("lighthouse_emitter: SWEEP_LEN must be even, non-zero and below 15 us");
    end
    if (SYNC_SPACE <= MAX_SYNC) begin : g_err_space
        $error("lighthouse_emitter: SYNC_SPACE must exceed the longest sync pulse");
    end
    if (SYNC_SPACE + MAX_SYNC + SWEEP_LEN + SYNC_STEP >= FRAME_LEN) begin : g_err_len
        $error("lighthouse_emitter: FRAME_LEN too short for the sync pulses");
    end

    emit_state_e      state_q;
    logic [WIDTH-1:0] timer_q;
    logic [1:0]       frame_idx_q;
    logic [1:0]       ootx_q;
    logic [WIDTH-1:0] angle_q;
    logic             pin_q;
    logic             ack_q;
    logic             err_q;

    logic [WIDTH-1:0] t_n;
    logic [1:0]       idx_n;
    logic [3:0][WIDTH-1:0] angles;
    logic [WIDTH-1:0] angle_sel;
    logic [WIDTH-1:0] len0, len1;
    logic [EW-1:0]    r_ext, a_ext;
    logic             angle_ok;
    logic [WIDTH-1:0] r_t, sweep_start, sweep_end;

    assign t_n    = timer_q + 1'b1;
    assign idx_n  = frame_idx_q + 2'd1;
    assign angles = {angle3_i, angle2_i, angle1_i, angle0_i};
    // A new frame out of TAIL already belongs to the next index.
    assign angle_sel = angles[(state_q == ST_TAIL) ? idx_n : frame_idx_q];

    // Frame f sweeps on sync0 when f[1]=0, else on sync1; the other sync
    // carries skip with the same axis.
    lighthouse_sync_encode #(
        .WIDTH(WIDTH), .SYNC_BASE(SYNC_BASE), .SYNC_STEP(SYNC_STEP)
    ) u_enc0 (
        .skip_i (frame_idx_q[1]),
        .data_i (ootx_q[0]),
        .axis_i (~frame_idx_q[0]),
        .len_o  (len0)
    );

    lighthouse_sync_encode #(
        .WIDTH(WIDTH), .SYNC_BASE(SYNC_BASE), .SYNC_STEP(SYNC_STEP)
    ) u_enc1 (
        .skip_i (~frame_idx_q[1]),
        .data_i (ootx_q[1]),
        .axis_i (~frame_idx_q[0]),
        .len_o  (len1)
    );

    // R is fixed per frame (sync1 fall is at SYNC_SPACE), so the whole sweep
    // window follows from latched values. Range check is done wide so a huge
    // angle cannot wrap into a valid-looking value.
    assign r_ext       = EW'(SYNC_SPACE) + EW'(len1);
    assign a_ext       = EW'(angle_q);
    assign angle_ok    = (a_ext >= EW'(HALF)) &&
                         (r_ext + a_ext + EW'(HALF) <= EW'(FRAME_LEN - SYNC_STEP));
    assign r_t         = WIDTH'(r_ext);
    assign sweep_start = WIDTH'(r_ext + a_ext - EW'(HALF));
    assign sweep_end   = sweep_start + WIDTH'(SWEEP_LEN);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= ST_IDLE;
            timer_q     <= '0;
            frame_idx_q <= '0;
            ootx_q      <= '0;
            angle_q     <= '0;
            pin_q       <= 1'b1;
            ack_q       <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            ack_q <= 1'b0;
            err_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (enable_i) begin
                        state_q <= ST_SYNC0_LO;
                        timer_q <= '0;
                        pin_q   <= 1'b0;
                        ack_q   <= 1'b1;
                        ootx_q  <= ootx_i;
                        angle_q <= angle_sel;
                    end
                end
                ST_SYNC0_LO: begin
                    timer_q <= t_n;
                    if (t_n == len0) begin
                        state_q <= ST_SYNC0_HI;
                        pin_q   <= 1'b1;
                    end
                end
                ST_SYNC0_HI: begin
                    timer_q <= t_n;
                    if (t_n == WIDTH'(SYNC_SPACE)) begin
                        state_q <= ST_SYNC1_LO;
                        pin_q   <= 1'b0;
                    end
                end
                ST_SYNC1_LO: begin
                    timer_q <= t_n;
                    if (t_n == r_t) begin
                        if (!angle_ok) begin
                            state_q <= ST_SWEEP_WAIT;
                            pin_q   <= 1'b1;
                            err_q   <= 1'b1;
                        end else if (sweep_start == t_n) begin
                            // Angle of exactly SWEEP_LEN/2: sweep starts on R.
                            state_q <= ST_SWEEP_LO;
                        end else begin
                            state_q <= ST_SWEEP_WAIT;
                            pin_q   <= 1'b1;
                        end
                    end
                end
                ST_SWEEP_WAIT: begin
                    timer_q <= t_n;
                    if (!angle_ok) begin
                        state_q <= ST_TAIL;
                    end else if (t_n == sweep_start) begin
                        state_q <= ST_SWEEP_LO;
                        pin_q   <= 1'b0;
                    end
                end
                ST_SWEEP_LO: begin
                    timer_q <= t_n;
                    if (t_n == sweep_end) begin
                        state_q <= ST_TAIL;
                        pin_q   <= 1'b1;
                    end
                end
                ST_TAIL: begin
                    if (timer_q == WIDTH'(FRAME_LEN - 1)) begin
                        frame_idx_q <= idx_n;
                        timer_q     <= '0;
                        if (enable_i) begin
                            state_q <= ST_SYNC0_LO;
                            pin_q   <= 1'b0;
                            ack_q   <= 1'b1;
                            ootx_q  <= ootx_i;
                            angle_q <= angle_sel;
                        end else begin
                            state_q <= ST_IDLE;
                        end
                    end else begin
                        timer_q <= t_n;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    pin_q   <= 1'b1;
                end
            endcase
        end
    end

    assign ootx_ack_o  = ack_q;
    assign frame_idx_o = frame_idx_q;
    assign angle_err_o = err_q;
    assign busy_o      = (state_q != ST_IDLE);
    assign pin_o       = pin_q;

endmodule

// File: tb/tb_lighthouse_emitter.sv
// ----------------------------------------------------------------------------
// tb_lighthouse_emitter
// Self-checking bench for lighthouse_emitter with scaled-down frame timing.
// A vector table of per-frame inputs with model-derived expectations is
// applied frame by frame; expectations go into a queue as each frame's
// inputs are driven, and a pin monitor pops and checks them as frames start.
// Hand-written sequences cover reset idle, enable drop and reset mid-frame.
// ----------------------------------------------------------------------------
module tb_lighthouse_emitter;

    localparam int W     = 12;
    localparam int FLEN  = 1200;
    localparam int SPACE = 200;
    localparam int BASE  = 48;
    localparam int STEP  = 8;
    localparam int SWL   = 10;
    localparam int H     = SWL / 2;

    typedef struct {
        int idx;
        int l0;
        int l1;
        int aofs;
        bit err;
    } exp_t;

    typedef struct {
        logic [1:0]          ootx;
        logic [3:0][W-1:0]   ang;
        exp_t                e;
    } tv_t;

    logic clk, rst_n, enable;
    logic [3:0][W-1:0] ang_drv;
    logic [1:0] ootx;
    logic ack, aerr, busy, pin;
    logic [1:0] fidx;

    lighthouse_emitter #(
        .WIDTH(W), .FRAME_LEN(FLEN), .SYNC_SPACE(SPACE),
        .SYNC_BASE(BASE), .SYNC_STEP(STEP), .SWEEP_LEN(SWL)
    ) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .enable_i    (enable),
        .angle0_i    (ang_drv[0]),
        .angle1_i    (ang_drv[1]),
        .angle2_i    (ang_drv[2]),
        .angle3_i    (ang_drv[3]),
        .ootx_i      (ootx),
        .ootx_ack_o  (ack),
        .frame_idx_o (fidx),
        .angle_err_o (aerr),
        .busy_o      (busy),
        .pin_o       (pin)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;
    exp_t q[$];

    task automatic chk(input string name, input longint act, input longint exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int sync_len(input int code);
        return BASE + code * STEP + STEP / 2;
    endfunction

    function automatic exp_t model(input int f, input logic [1:0] o, input int a);
        exp_t e;
        int b1, b0, r;
        b1 = (f >> 1) & 1;
        b0 = f & 1;
        e.idx  = f;
        e.l0   = sync_len(b1 * 4 + int'(o[0]) * 2 + (1 - b0));
        e.l1   = sync_len((1 - b1) * 4 + int'(o[1]) * 2 + (1 - b0));
        r      = SPACE + e.l1;
        e.err  = !(a >= H && r + a + H <= FLEN - STEP);
        e.aofs = a - H;
        return e;
    endfunction

    function automatic int amax(input int f, input logic [1:0] o);
        exp_t e;
        e = model(f, o, 0);
        return FLEN - STEP - H - (SPACE + e.l1);
    endfunction

    // ---------------- pin monitor / scoreboard consumer ----------------
    int   cyc = 0;
    int   fstart, ffall, rrel, npulse, nerr;
    bit   open = 0;
    exp_t cur;
    logic prev_pin = 1'b1;

    task automatic close_frame();
        chk("pulse_count", npulse, cur.err ? 2 : 3);
        chk("angle_err_count", nerr, int'(cur.err));
        chk("frame_period", cyc - fstart, FLEN);
        open = 0;
    endtask

    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            if (!rst_n) begin
                open     = 0;
                prev_pin = pin;
            end else begin
                if (open && !busy) close_frame();
                if (ack) begin
                    if (open) close_frame();
                    if (q.size() == 0) begin
                        chk("unexpected_frame", 1, 0);
                    end else begin
                        cur    = q.pop_front();
                        open   = 1;
                        fstart = cyc;
                        npulse = 0;
                        nerr   = 0;
                        rrel   = -1;
                        chk("frame_idx_at_ack", fidx, cur.idx);
                    end
                end
                if (prev_pin && !pin) begin
                    ffall = cyc;
                    if (!open) chk("stray_pulse", 1, 0);
                end
                if (!prev_pin && pin && open) begin
                    case (npulse)
                        0: begin
                            chk("sync0_fall_ofs", ffall - fstart, 0);
                            chk("sync0_len", cyc - ffall, cur.l0);
                        end
                        1: begin
                            chk("sync1_fall_ofs", ffall - fstart, SPACE);
                            chk("sync1_len", cyc - ffall, cur.l1);
                            rrel = cyc - fstart;
                        end
                        2: begin
                            chk("sweep_fall_ofs", ffall - fstart - rrel, cur.aofs);
                            chk("sweep_len", cyc - ffall, SWL);
                        end
                        default: chk("extra_pulse", npulse, 2);
                    endcase
                    npulse++;
                end
                if (aerr && open) begin
                    nerr++;
                    chk("angle_err_time", cyc - fstart, rrel);
                end
                prev_pin = pin;
            end
        end
    end

    // ---------------- stimulus ----------------
    tv_t tv[8];

    task automatic apply(input tv_t v);
        ootx    = v.ootx;
        ang_drv = v.ang;
        q.push_back(v.e);
    endtask

    function automatic tv_t mkvec(input int f, input logic [1:0] o, input int a);
        tv_t v;
        v.ootx = o;
        for (int k = 0; k < 4; k++) v.ang[k] = W'($urandom_range(0, 4095));
        v.ang[f] = W'(a);
        v.e = model(f, o, a);
        return v;
    endfunction

    task automatic wait_ack();
        bit seen;
        seen = 0;
        for (int i = 0; i < 2 * FLEN && !seen; i++) begin
            @(posedge clk);
            #1;
            if (ack) seen = 1;
        end
        if (!seen) chk("ack_timeout", 0, 1);
    endtask

    task automatic wait_idle();
        bit seen;
        seen = 0;
        for (int i = 0; i < 2 * FLEN && !seen; i++) begin
            @(posedge clk);
            #1;
            if (!busy) seen = 1;
        end
        if (!seen) chk("idle_timeout", 0, 1);
    endtask

    initial begin
        int bad;
        int r2;
        rst_n   = 1'b0;
        enable  = 1'b0;
        ootx    = 2'b00;
        ang_drv = '0;

        tv[0] = mkvec(0, 2'b00, 300);
        tv[1] = mkvec(1, 2'b11, 450);
        tv[2] = mkvec(2, 2'b01, H + 1);
        tv[3] = mkvec(3, 2'b10, H - 1);
        tv[4] = mkvec(0, 2'b11, amax(0, 2'b11));
        tv[5] = mkvec(1, 2'b00, amax(1, 2'b00) + 1);
        tv[6] = mkvec(2, 2'b10, 4000);
        tv[7] = mkvec(3, 2'b01, 700);

        // Reset values.
        repeat (3) @(posedge clk);
        #1;
        chk("rst_pin", pin, 1);
        chk("rst_busy", busy, 0);
        chk("rst_ack", ack, 0);
        chk("rst_err", aerr, 0);
        chk("rst_frame_idx", fidx, 0);

        // Idle with enable low: nothing moves.
        @(negedge clk);
        rst_n = 1'b1;
        bad = 0;
        for (int i = 0; i < 2000; i++) begin
            @(posedge clk);
            #1;
            if (pin !== 1'b1 || busy !== 1'b0 || ack !== 1'b0) bad++;
        end
        chk("idle_bad_cycles", bad, 0);

        // Table: one vector per frame, inputs changed mid-frame each time.
        apply(tv[0]);
        enable = 1'b1;
        for (int i = 1; i < 8; i++) begin
            wait_ack();
            apply(tv[i]);
        end
        wait_ack();
        enable = 1'b0;
        wait_idle();
        chk("idx_after_table", fidx, 0);

        // Drop enable during SWEEP_WAIT of frame 2.
        apply(mkvec(0, 2'b01, 350));
        enable = 1'b1;
        wait_ack();
        apply(mkvec(1, 2'b10, 400));
        wait_ack();
        apply(mkvec(2, 2'b11, 600));
        wait_ack();
        r2 = SPACE + model(2, 2'b11, 600).l1;
        repeat (r2 + 3) @(posedge clk);
        #1;
        chk("busy_in_sweep_wait", busy, 1);
        enable = 1'b0;
        wait_idle();
        chk("idx_after_drop", fidx, 3);

        // Re-enable: frame 3 next, then reset during its SYNC1_LO.
        apply(mkvec(3, 2'b00, 500));
        enable = 1'b1;
        wait_ack();
        repeat (SPACE + 5) @(posedge clk);
        #1;
        chk("pin_low_in_sync1", pin, 0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_async_pin", pin, 1);
        chk("rst_async_busy", busy, 0);
        chk("rst_async_idx", fidx, 0);
        repeat (3) @(posedge clk);
        apply(mkvec(0, 2'b10, 250));
        @(negedge clk);
        rst_n = 1'b1;
        wait_ack();
        chk("idx_after_reset", fidx, 0);
        enable = 1'b0;
        wait_idle();
        repeat (3) @(posedge clk);
        chk("queue_drained", q.size(), 0);
        chk("no_open_frame", int'(open), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
